// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle between the instruction front-end and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_funct;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_use_acc;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic             rsp_err;

  modport master (
    output req_valid, req_funct, req_a, req_b, req_use_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_overflow, rsp_err
  );

  modport slave (
    input  req_valid, req_funct, req_a, req_b, req_use_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_overflow, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Registered controller that feeds a combinational ALU one op at a time, captures its
// flags, owns the accumulator and a saturating error counter.
module alu_sequencer #(
  parameter int WIDTH        = 8,
  parameter bit ERR_ON_CARRY = 1'b1,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_sequencer_if.slave       bus,
  input  logic                 err_clear,
  output logic [3:0]           alu_funct,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  output logic [1:0]           state,
  output logic [WIDTH-1:0]     acc,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    READY = 2'd0,
    ARITH = 2'd1,
    LOGIC = 2'd2,
    ERROR = 2'd3
  } seqState_e;

  seqState_e             stateQ, stateD;
  logic [3:0]            functQ, functD;
  logic [WIDTH-1:0]      aQ, aD, bQ, bD;
  logic [WIDTH-1:0]      accQ, accD;
  logic                  rspValidQ, rspValidD;
  logic [WIDTH-1:0]      rspDataQ, rspDataD;
  logic                  rspCarryQ, rspCarryD;
  logic                  rspOvfQ, rspOvfD;
  logic                  rspErrQ, rspErrD;
  logic [ERR_CNT_W-1:0]  errCntQ, errCntD;
  logic                  accept;
  logic                  opErr;
  logic                  errEvent;

  // Ready depends on registers only, so no combinational path from request to response.
  assign bus.req_ready = (stateQ == READY) && !rspValidQ;
  assign accept        = bus.req_valid && bus.req_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stateD    = stateQ;
    functD    = functQ;
    aD        = aQ;
    bD        = bQ;
    accD      = accQ;
    rspValidD = rspValidQ;
    rspDataD  = rspDataQ;
    rspCarryD = rspCarryQ;
    rspOvfD   = rspOvfQ;
    rspErrD   = rspErrQ;
    errCntD   = errCntQ;
    opErr     = 1'b0;
    errEvent  = 1'b0;

    if (rspValidQ && bus.rsp_ready) rspValidD = 1'b0;

    unique case (stateQ)
      READY: begin
        if (accept) begin
          functD = bus.req_funct;
          aD     = bus.req_use_acc ? accQ : bus.req_a;
          bD     = bus.req_b;
          if (bus.req_funct[3]) begin
            // Undefined function codes close immediately with an error response.
            stateD    = ERROR;
            rspValidD = 1'b1;
            rspDataD  = '0;
            rspCarryD = 1'b0;
            rspOvfD   = 1'b0;
            rspErrD   = 1'b1;
            errEvent  = 1'b1;
          end else if (bus.req_funct[2]) begin
            stateD = LOGIC;
          end else begin
            stateD = ARITH;
          end
        end
      end
      ARITH: begin
        opErr     = (!functQ[1] && alu_overflow) || (functQ[1] && alu_carry && ERR_ON_CARRY);
        rspValidD = 1'b1;
        rspDataD  = alu_out;
        rspCarryD = alu_carry;
        rspOvfD   = alu_overflow;
        rspErrD   = opErr;
        if (opErr) begin
          errEvent = 1'b1;
          stateD   = ERROR;
        end else begin
          accD   = alu_out;
          stateD = READY;
        end
      end
      LOGIC: begin
        rspValidD = 1'b1;
        rspDataD  = alu_out;
        rspCarryD = 1'b0;
        rspOvfD   = 1'b0;
        rspErrD   = 1'b0;
        accD      = alu_out;
        stateD    = READY;
      end
      ERROR: begin
        if (err_clear) stateD = READY;
      end
      default: stateD = READY;
    endcase

    if (errEvent && (errCntQ != '1)) errCntD = errCntQ + ERR_CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= READY;
      functQ    <= '0;
      aQ        <= '0;
      bQ        <= '0;
      accQ      <= '0;
      rspValidQ <= 1'b0;
      rspDataQ  <= '0;
      rspCarryQ <= 1'b0;
      rspOvfQ   <= 1'b0;
      rspErrQ   <= 1'b0;
      errCntQ   <= '0;
    end else begin
      stateQ    <= stateD;
      functQ    <= functD;
      aQ        <= aD;
      bQ        <= bD;
      accQ      <= accD;
      rspValidQ <= rspValidD;
      rspDataQ  <= rspDataD;
      rspCarryQ <= rspCarryD;
      rspOvfQ   <= rspOvfD;
      rspErrQ   <= rspErrD;
      errCntQ   <= errCntD;
    end
  end

  assign alu_funct        = functQ;
  assign alu_a            = aQ;
  assign alu_b            = bQ;
  assign acc              = accQ;
  assign state            = stateQ;
  assign err_cnt          = errCntQ;
  assign bus.rsp_valid    = rspValidQ;
  assign bus.rsp_data     = rspDataQ;
  assign bus.rsp_carry    = rspCarryQ;
  assign bus.rsp_overflow = rspOvfQ;
  assign bus.rsp_err      = rspErrQ;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed and random ops against an arithmetic
// reference model, with a behavioural ALU closing the loop around the DUT.
module tb_alu_sequencer;
  localparam int WIDTH        = 8;
  localparam bit ERR_ON_CARRY = 1'b1;
  localparam int ERR_CNT_W    = 8;
  localparam int FULL         = 1 << WIDTH;
  localparam int HALF         = 1 << (WIDTH - 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 err_clear;
  logic [3:0]           alu_funct;
  logic [WIDTH-1:0]     alu_a, alu_b, alu_out;
  logic                 alu_carry, alu_overflow;
  logic [1:0]           state;
  logic [WIDTH-1:0]     acc;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [WIDTH:0]       aluWide;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int mAcc;
  int mErrCnt;
  int mState;
  bit mPending;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_sequencer #(
    .WIDTH(WIDTH), .ERR_ON_CARRY(ERR_ON_CARRY), .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_clear(err_clear),
    .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .state(state), .acc(acc), .err_cnt(err_cnt)
  );

  // Behavioural ALU; flags on logic/undefined codes are deliberately nonzero garbage.
  always_comb begin
    aluWide      = '0;
    alu_out      = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_funct)
      4'd0: begin
        aluWide      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = aluWide[WIDTH-1:0];
        alu_carry    = aluWide[WIDTH];
        alu_overflow = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'd1: begin
        aluWide      = {1'b0, alu_a} - {1'b0, alu_b};
        alu_out      = aluWide[WIDTH-1:0];
        alu_carry    = aluWide[WIDTH];
        alu_overflow = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_out[WIDTH-1] != alu_a[WIDTH-1]);
      end
      4'd2: begin alu_out = alu_a << 1; alu_carry = alu_a[WIDTH-1]; end
      4'd3: begin alu_out = alu_a >> 1; alu_carry = alu_a[0]; end
      4'd4: begin alu_out = alu_a & alu_b; alu_carry = alu_a[0]; alu_overflow = alu_b[0]; end
      4'd5: begin alu_out = alu_a | alu_b; alu_carry = alu_a[0]; alu_overflow = alu_b[0]; end
      4'd6: begin alu_out = alu_a ^ alu_b; alu_carry = alu_a[0]; alu_overflow = alu_b[0]; end
      4'd7: begin alu_out = ~alu_a;        alu_carry = alu_a[0]; alu_overflow = alu_b[0]; end
      default: begin alu_out = 8'hA5; alu_carry = 1'b1; alu_overflow = 1'b1; end
    endcase
  end

  function automatic int toSigned(input int v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  // Reference ALU in plain integer arithmetic.
  function automatic void refAlu(input int f, input int a, input int b,
                                 output int r, output bit c, output bit o);
    int s;
    r = 0; c = 1'b0; o = 1'b0;
    case (f)
      0: begin
        s = a + b; r = s % FULL; c = (s >= FULL);
        s = toSigned(a) + toSigned(b); o = (s >= HALF) || (s < -HALF);
      end
      1: begin
        s = a - b; r = (s + FULL) % FULL; c = (s < 0);
        s = toSigned(a) - toSigned(b); o = (s >= HALF) || (s < -HALF);
      end
      2: begin r = (a * 2) % FULL; c = (a >= HALF); end
      3: begin r = a / 2; c = (a % 2) == 1; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = (FULL - 1) - a;
      default: r = 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int f, input int a, input int b, input bit useAcc);
    int  opA, r, lat, expData, expState;
    bit  c, o, err, expC, expO;
    opA = useAcc ? mAcc : a;
    bus.req_valid   = 1'b1;
    bus.req_funct   = 4'(f);
    bus.req_a       = WIDTH'(a);
    bus.req_b       = WIDTH'(b);
    bus.req_use_acc = useAcc;
    lat = 0;
    while (!bus.req_ready && lat < 20) begin step(); lat++; end
    check("req_ready_before_accept", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 1'b0;
    check("state_after_accept", 32'(state), (f < 4) ? 1 : (f < 8) ? 2 : 3);
    check("alu_funct", 32'(alu_funct), f);
    check("alu_a", 32'(alu_a), opA);
    check("alu_b", 32'(alu_b), b);

    refAlu(f, opA, b, r, c, o);
    if (f >= 8) begin
      err = 1'b1; expData = 0; expC = 1'b0; expO = 1'b0;
    end else if (f < 4) begin
      err = ((f < 2) && o) || ((f >= 2) && c && ERR_ON_CARRY);
      expData = r; expC = c; expO = o;
    end else begin
      err = 1'b0; expData = r; expC = 1'b0; expO = 1'b0;
    end
    if (!err) mAcc = expData;
    if (err && mErrCnt < (1 << ERR_CNT_W) - 1) mErrCnt++;
    expState = err ? 3 : 0;
    mState   = expState;
    mPending = 1'b1;

    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin step(); lat++; end
    check("rsp_latency", lat, (f >= 8) ? 1 : 2);
    check("rsp_data", 32'(bus.rsp_data), expData);
    check("rsp_carry", 32'(bus.rsp_carry), 32'(expC));
    check("rsp_overflow", 32'(bus.rsp_overflow), 32'(expO));
    check("rsp_err", 32'(bus.rsp_err), 32'(err));
    check("acc", 32'(acc), mAcc);
    check("state_after_rsp", 32'(state), expState);
    check("err_cnt", 32'(err_cnt), mErrCnt);
    check("req_ready_while_pending", 32'(bus.req_ready), 0);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    mPending = 1'b0;
    check("rsp_valid_after_consume", 32'(bus.rsp_valid), 0);
    check("req_ready_after_consume", 32'(bus.req_ready), (mState == 0) ? 1 : 0);
  endtask

  task automatic clearErr();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    mState = 0;
    check("state_after_clear", 32'(state), 0);
    check("req_ready_after_clear", 32'(bus.req_ready), mPending ? 0 : 1);
  endtask

  initial begin
    int f;
    rst = 1'b1; err_clear = 1'b0;
    bus.req_valid = 1'b0; bus.req_funct = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_use_acc = 1'b0; bus.rsp_ready = 1'b0;
    mAcc = 0; mErrCnt = 0; mState = 0; mPending = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    check("reset_state", 32'(state), 0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset_acc", 32'(acc), 0);
    check("reset_err_cnt", 32'(err_cnt), 0);
    check("reset_req_ready", 32'(bus.req_ready), 1);
    check("reset_alu_regs", {20'd0, alu_funct, alu_a}, 0);

    issue(0, 'h10, 'h22, 1'b0); consume();
    issue(1, 'h00, 'h02, 1'b1); consume();
    check("acc_after_sub", 32'(acc), 'h30);

    issue(0, 'h7F, 'h01, 1'b0); consume();
    check("req_ready_in_error", 32'(bus.req_ready), 0);
    clearErr();

    // err_clear outside ERROR must change nothing.
    err_clear = 1'b1; step(); err_clear = 1'b0;
    check("err_clear_ignored_state", 32'(state), 0);
    check("err_clear_ignored_acc", 32'(acc), mAcc);

    // Response held back while a second request waits; neither may move.
    issue(6, 'hF0, 'hFF, 1'b0);
    bus.req_valid = 1'b1; bus.req_funct = 4'd0; bus.req_a = 8'h01; bus.req_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_rsp_data", 32'(bus.rsp_data), 'h0F);
      check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
      check("hold_req_ready", 32'(bus.req_ready), 0);
      check("hold_alu_funct", 32'(alu_funct), 6);
    end
    bus.req_valid = 1'b0;
    consume();

    // Shift carry is an error; clear it while the response is still pending.
    issue(2, 'h81, 'h00, 1'b0);
    clearErr();
    consume();

    issue(9, 'h12, 'h34, 1'b0); consume(); clearErr();

    for (int i = 0; i < 60; i++) begin
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
      issue(f, int'($urandom_range(0, FULL - 1)), int'($urandom_range(0, FULL - 1)),
            1'($urandom_range(0, 1)));
      if (mState == 3 && $urandom_range(0, 1) == 1) begin
        clearErr(); consume();
      end else begin
        consume();
        if (mState == 3) clearErr();
      end
    end

    for (int i = 0; i < 300; i++) begin
      issue(9, 0, 0, 1'b0); consume(); clearErr();
    end
    check("err_cnt_saturated", 32'(err_cnt), 'hFF);

    issue(0, 'h05, 'h06, 1'b0); consume();

    // Reset landing on the ARITH cycle aborts the op.
    bus.req_valid = 1'b1; bus.req_funct = 4'd0; bus.req_a = 8'h01; bus.req_b = 8'h02;
    bus.req_use_acc = 1'b0;
    step();
    bus.req_valid = 1'b0;
    check("pre_reset_arith", 32'(state), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check("midop_reset_state", 32'(state), 0);
    check("midop_reset_rsp_valid", 32'(bus.rsp_valid), 0);
    check("midop_reset_acc", 32'(acc), 0);
    check("midop_reset_err_cnt", 32'(err_cnt), 0);
    step();
    check("midop_reset_no_late_rsp", 32'(bus.rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
